// File: rtl/i2c_master_writer.sv
// Single-master I2C write engine: START, {SLAVE_ADDR,W}, register pointer, data, STOP.
// Optional macro I2C_MASTER_RETRY_EN: an address NACK is retried up to twice.
module i2c_master_writer #(
  parameter int         CLK_FREQ   = 100_000_000,
  parameter int         SCL_FREQ   = 100_000,
  parameter logic [6:0] SLAVE_ADDR = 7'h28
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       scl_o,
  inout  wire        sda_io
);

  localparam int              QTR       = CLK_FREQ / (4 * SCL_FREQ);
  localparam int              CW        = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0]   QTR_LAST  = CW'(QTR - 1);
  localparam logic [7:0]      ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    data_q, data_d;
  logic          ack_err_q, ack_err_d;
  logic          nack_q, nack_d;
  logic          sda_low;
  logic          tick, sample, end_bit;
`ifdef I2C_MASTER_RETRY_EN
  logic [1:0]    retry_q, retry_d;
  logic          retry_go_q, retry_go_d;
`endif

  assign tick    = (cnt_q == QTR_LAST);
  assign sample  = tick && (phase_q == 2'd1);
  assign end_bit = tick && (phase_q == 2'd3);

  assign sda_io    = sda_low ? 1'b0 : 1'bz;
  assign ack_err_o = ack_err_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      ack_err_q  <= 1'b0;
      nack_q     <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
      retry_q    <= '0;
      retry_go_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      ack_err_q  <= ack_err_d;
      nack_q     <= nack_d;
`ifdef I2C_MASTER_RETRY_EN
      retry_q    <= retry_d;
      retry_go_q <= retry_go_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    phase_d   = phase_q + {1'b0, tick};
    bit_d     = bit_q;
    shift_d   = shift_q;
    reg_d     = reg_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    nack_d    = sample ? sda_io : nack_q;
`ifdef I2C_MASTER_RETRY_EN
    retry_d    = retry_q;
    retry_go_d = retry_go_q;
`endif
    scl_o     = 1'b1;
    sda_low   = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o  = 1'b0;
        cnt_d   = '0;
        phase_d = '0;
        if (start_i) begin
          state_d   = S_START;
          reg_d     = reg_addr_i;
          data_d    = wdata_i;
          shift_d   = ADDR_BYTE;
          bit_d     = '0;
          ack_err_d = 1'b0;
`ifdef I2C_MASTER_RETRY_EN
          retry_d    = '0;
          retry_go_d = 1'b0;
`endif
        end
      end
      S_START: begin
        scl_o   = (phase_q != 2'd3);
        sda_low = phase_q[1];
        if (end_bit) state_d = S_ADDR;
      end
      S_ADDR, S_REG, S_DATA: begin
        scl_o   = phase_q[0] ^ phase_q[1];
        sda_low = ~shift_q[7];
        if (end_bit) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (state_q == S_ADDR)     state_d = S_ACK1;
            else if (state_q == S_REG) state_d = S_ACK2;
            else                       state_d = S_ACK3;
          end
        end
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        scl_o = phase_q[0] ^ phase_q[1];
        if (end_bit) begin
          if (nack_q) begin
            state_d   = S_STOP;
            ack_err_d = 1'b1;
`ifdef I2C_MASTER_RETRY_EN
            // Address NACKs with attempts left stay silent and restart after STOP.
            if (state_q == S_ACK1 && retry_q != 2'd2) begin
              ack_err_d  = 1'b0;
              retry_go_d = 1'b1;
              retry_d    = retry_q + 2'd1;
            end
`endif
          end else if (state_q == S_ACK1) begin
            state_d = S_REG;
            shift_d = reg_q;
          end else if (state_q == S_ACK2) begin
            state_d = S_DATA;
            shift_d = data_q;
          end else begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        scl_o   = (phase_q != 2'd0);
        sda_low = ~phase_q[1];
        if (end_bit) begin
          state_d = S_DONE;
`ifdef I2C_MASTER_RETRY_EN
          if (retry_go_q) begin
            state_d    = S_START;
            retry_go_d = 1'b0;
            shift_d    = ADDR_BYTE;
          end
`endif
        end
      end
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        cnt_d   = '0;
        phase_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
